// File: rtl/uart_defs.sv
// Shared UART definitions: pacer FSM encodings and default line-rate constants
// used by the receiver, transmitter and loopback FIFO.
package uart_defs;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned UART_BPS = 115_200;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } loop_state_e;

endpackage

// File: rtl/uart_loop_fifo_if.sv
// Receiver-to-FIFO and FIFO-to-transmitter handshake bundle for the loopback path.
interface uart_loop_fifo_if;
    import uart_defs::*;

    logic              recv_done;
    logic [BYTE_W-1:0] recv_data;
    logic              send_busy;
    logic              send_en;
    logic [BYTE_W-1:0] send_data;

    // master: receiver/transmitter side; slave: the loopback FIFO
    modport master (
        output recv_done,
        output recv_data,
        output send_busy,
        input  send_en,
        input  send_data
    );

    modport slave (
        input  recv_done,
        input  recv_data,
        input  send_busy,
        output send_en,
        output send_data
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered occupancy/full/empty and
// combinational read data at the read pointer.
module uart_sync_fifo
    import uart_defs::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BYTE_W-1:0]     wr_data,
    output logic [BYTE_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   cnt,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_nxt;

    assign rd_data = mem[rd_ptr];

    // Push and pop together leave the occupancy unchanged
    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == CNT_W'(0));
            full  <= (cnt_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_loop_fifo.sv
// UART loopback buffer: queues received bytes and paces them into the transmitter.
// Optional dropped-byte counter port enabled by UART_FIFO_OVF_CNT_EN.
module uart_loop_fifo
    import uart_defs::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned BUSY_WAIT  = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    uart_loop_fifo_if.slave       lf,
    output logic [DEPTH_LOG2:0]   fifo_cnt,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  ovf_flag
`ifdef UART_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    localparam int unsigned TMO_W = (BUSY_WAIT > 2) ? $clog2(BUSY_WAIT) : 1;

    loop_state_e       state;
    loop_state_e       state_nxt;
    logic [TMO_W-1:0]  tmo;
    logic [TMO_W-1:0]  tmo_nxt;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [BYTE_W-1:0] rd_data;

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push_c = lf.recv_done && (!fifo_full || pop_c);
    assign drop_c = lf.recv_done && fifo_full && !pop_c;

    uart_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .push    (push_c),
        .pop     (pop_c),
        .wr_data (lf.recv_data),
        .rd_data (rd_data),
        .cnt     (fifo_cnt),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Pacer: one byte in flight; a busy that never rises times out and counts as sent
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        pop_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !lf.send_busy) begin
                    pop_c     = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                tmo_nxt   = '0;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (lf.send_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo == TMO_W'(BUSY_WAIT - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!lf.send_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            tmo          <= '0;
            lf.send_en   <= 1'b0;
            lf.send_data <= '0;
            ovf_flag     <= 1'b0;
        end else begin
            state      <= state_nxt;
            tmo        <= tmo_nxt;
            lf.send_en <= (state_nxt == ST_START);
            if (pop_c)  lf.send_data <= rd_data;
            if (drop_c) ovf_flag     <= 1'b1;
        end
    end

`ifdef UART_FIFO_OVF_CNT_EN
    // Saturating count of discarded bytes
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovf_cnt <= '0;
        end else if (drop_c && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: queue-based reference model, a transmitter emulator
// and directed plus randomized traffic.
module tb_uart_loop_fifo;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BW    = 4;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [4:0] fifo_cnt;
    logic       fifo_empty;
    logic       fifo_full;
    logic       ovf_flag;
`ifdef UART_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    uart_loop_fifo_if lf();

    uart_loop_fifo #(
        .DEPTH_LOG2 (DL2),
        .BUSY_WAIT  (BW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .lf         (lf),
        .fifo_cnt   (fifo_cnt),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .ovf_flag   (ovf_flag)
`ifdef UART_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter emulator: busy for a random 1..6 cycles after each start pulse
    logic force_busy = 1'b0;
    logic emu_busy   = 1'b0;
    logic emu_dead   = 1'b0;
    logic emu_rand   = 1'b0;
    int   emu_cnt    = 0;

    assign lf.send_busy = force_busy | emu_busy;

    always @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            emu_cnt = 0;
        end else begin
            if (emu_cnt > 0) emu_cnt--;
            if (lf.send_en && !emu_dead && !(emu_rand && $urandom_range(0, 9) == 0))
                emu_cnt = int'($urandom_range(1, 6));
        end
        emu_busy = (emu_cnt != 0);
    end

    // Reference model: byte queue plus cycle arithmetic for the launch rules
    logic [7:0] mq[$];
    logic       m_free = 1'b1;
    logic       m_seen = 1'b0;
    logic       m_en   = 1'b0;
    logic       m_pop  = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovf  = 1'b0;
    int         m_ovfc = 0;
    int         m_cyc  = 0;
    int         m_pop_cyc = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mq.delete();
            m_free = 1'b1; m_seen = 1'b0; m_en = 1'b0; m_data = 8'h00;
            m_ovf = 1'b0; m_ovfc = 0; m_cyc = 0; m_pop_cyc = 0;
        end else begin
            m_pop = m_free && (mq.size() != 0) && !lf.send_busy;
            // busy is watched from two cycles after the pop; timeout after BW quiet cycles
            if (!m_free && m_cyc >= m_pop_cyc + 2) begin
                if (m_seen) begin
                    if (!lf.send_busy) m_free = 1'b1;
                end else if (lf.send_busy) begin
                    m_seen = 1'b1;
                end else if (m_cyc == m_pop_cyc + 1 + int'(BW)) begin
                    m_free = 1'b1;
                end
            end
            if (m_pop) begin
                m_free = 1'b0; m_seen = 1'b0; m_pop_cyc = m_cyc;
                m_data = mq.pop_front();
            end
            m_en = m_pop;
            if (lf.recv_done) begin
                if (mq.size() < DEPTH || m_pop) mq.push_back(lf.recv_data);
                else begin
                    m_ovf = 1'b1;
                    if (m_ovfc < 255) m_ovfc++;
                end
            end
            m_cyc++;
        end
    end

    logic [7:0] sent[$];
    int         n_pulses = 0;

    // Per-cycle comparison against the model
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            check("send_en", 32'(lf.send_en), 32'(m_en));
            check("send_data", 32'(lf.send_data), 32'(m_data));
            check("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
            check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
`ifdef UART_FIFO_OVF_CNT_EN
            check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovfc));
`endif
            if (lf.send_en) begin
                sent.push_back(lf.send_data);
                n_pulses++;
            end
        end
    end

    task automatic drive(input logic rd, input logic [7:0] d);
        @(negedge sys_clk);
        lf.recv_done = rd;
        lf.recv_data = d;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n    = 1'b0;
        lf.recv_done = 1'b0;
        force_busy   = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic drain();
        int quiet = 0;
        for (int k = 0; k < 3000; k++) begin
            drive(1'b0, 8'h00);
            if (fifo_empty && !lf.send_busy && !lf.send_en) quiet++;
            else quiet = 0;
            if (quiet >= 10) break;
        end
        check("drain_done", 32'(quiet >= 10), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int p1;
        int k;
        lf.recv_done = 1'b0;
        lf.recv_data = 8'h00;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst_send_en", 32'(lf.send_en), 32'd0);
        check("rst_send_data", 32'(lf.send_data), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_ovf_flag", 32'(ovf_flag), 32'd0);
        sys_rst_n = 1'b1;

        // Single byte: start pulse two cycles after the receive strobe
        repeat (8) drive(1'b0, 8'h00);
        drive(1'b1, 8'h5A);
        drive(1'b0, 8'h00);
        check("sb_empty_n1", 32'(fifo_empty), 32'd0);
        check("sb_cnt_n1", 32'(fifo_cnt), 32'd1);
        check("sb_en_n1", 32'(lf.send_en), 32'd0);
        drive(1'b0, 8'h00);
        check("sb_en_n2", 32'(lf.send_en), 32'd1);
        check("sb_data_n2", 32'(lf.send_data), 32'h5A);
        check("sb_cnt_n2", 32'(fifo_cnt), 32'd0);
        drain();

        // Burst while busy
        do_reset();
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
        repeat (3) drive(1'b0, 8'h00);
        check("burst_cnt", 32'(fifo_cnt), 32'd5);
        sent.delete();
        force_busy = 1'b0;
        drain();
        check("burst_n", 32'(sent.size()), 32'd5);
        for (int i = 0; i < 5 && i < sent.size(); i++)
            check("burst_order", 32'(sent[i]), 32'(i + 1));

        // Overflow, then push and pop together while full
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i <= 16; i++) drive(1'b1, 8'(i));
        drive(1'b0, 8'h00);
        check("ovf_cnt16", 32'(fifo_cnt), 32'd16);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_flag_set", 32'(ovf_flag), 32'd1);
`ifdef UART_FIFO_OVF_CNT_EN
        check("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
`endif
        sent.delete();
        drive(1'b1, 8'hA5);
        force_busy = 1'b0;
        drive(1'b0, 8'h00);
        check("pp_cnt16", 32'(fifo_cnt), 32'd16);
        check("pp_ovf_flag", 32'(ovf_flag), 32'd1);
        drain();
        check("pp_n", 32'(sent.size()), 32'd17);
        if (sent.size() == 17) begin
            check("pp_first", 32'(sent[0]), 32'h00);
            check("pp_last", 32'(sent[16]), 32'hA5);
        end

        // Busy never rises: next byte launched after the timeout
        do_reset();
        emu_dead = 1'b1;
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        p0 = -1; p1 = -1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 8'h00);
            if (lf.send_en) begin
                if (p0 < 0) p0 = i;
                else if (p1 < 0) p1 = i;
            end
        end
        check("tmo_first", 32'(p0), 32'd0);
        check("tmo_gap", 32'(p1 - p0), 32'd6);
        emu_dead = 1'b0;
        drain();

        // Reset in the start cycle with three bytes still queued
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h30 + i));
        drive(1'b0, 8'h00);
        force_busy = 1'b0;
        k = 0;
        while (k < 20) begin
            @(posedge sys_clk);
            #1;
            if (lf.send_en) break;
            k++;
        end
        check("mr_found_start", 32'(k < 20), 32'd1);
        check("mr_queued", 32'(fifo_cnt), 32'd3);
        sys_rst_n = 1'b0;
        #1;
        check("mr_send_en", 32'(lf.send_en), 32'd0);
        check("mr_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("mr_ovf_flag", 32'(ovf_flag), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        n_pulses  = 0;
        repeat (20) drive(1'b0, 8'h00);
        check("mr_no_pulses", 32'(n_pulses), 32'd0);

        // Randomized traffic with random busy lengths and occasional lost busy
        emu_rand = 1'b1;
        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 99) < 30), 8'($urandom));
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 99) < 85), 8'($urandom));
        emu_rand = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
